conv_accum: RTL and testbench

Convolution accumulator that consumes the parallel pixel/weight stream produced by the picture-input block. Each accepted beat carries one filter tap for `channel_all_num` output pixels and `conv_num` kernels. After `weight_num` accepted taps it emits one saturated result per (kernel, lane). It also counts windows so it can flag the end of a frame to the downstream pooling/writer stage.

---
 rtl/conv_accum_pkg.sv | 38 +++
 rtl/conv_accum_mac_lane.sv | 68 ++++++
 rtl/conv_accum.sv | 115 +++++++++++
 tb/tb_conv_accum.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/conv_accum_pkg.sv
// conv_accum_pkg: shared widths and helpers for the convolution accumulator.
//   elem_idx   - flat (kernel, lane) element index
//   slice_lsb  - LSB position of element idx in a packed vector of width-w fields
//   sat_shift  - arithmetic shift right (floor) then clamp to a signed nbits range
package conv_accum_pkg;

  localparam int unsigned BITS_DFLT = 16;
  localparam int unsigned PROD_BITS = 2 * BITS_DFLT;
  localparam int unsigned ACC_BITS  = 40;

  function automatic int unsigned elem_idx(input int unsigned c, input int unsigned p,
                                           input int unsigned lanes);
    return c * lanes + p;
  endfunction

  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

  // Operates on a 64-bit signed container so any accumulator up to 64 bits can use it;
  // callers sign-extend in and narrow the return value to nbits.
  function automatic logic signed [63:0] sat_shift(input  logic signed [63:0] acc,
                                                   input  int unsigned        frac,
                                                   input  int unsigned        nbits,
                                                   output logic               ovf);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh  = acc >>> frac;
    hi  = (64'sd1 <<< (nbits - 1)) - 64'sd1;
    lo  = ~hi;
    ovf = (sh > hi) || (sh < lo);
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/conv_accum_mac_lane.sv
// conv_mac_lane: one (kernel, lane) multiply / accumulate / saturate pipeline.
//   clk_i, rst_ni : clock, async active-low reset
//   in_en_i       : capture map_i/weight_i operands
//   mul_en_i      : register the operand product
//   acc_en_i      : fold the product into the accumulator
//   first_i       : with acc_en_i, product replaces the accumulator
//   out_en_i      : register the saturated, shifted accumulator into result_o
//   map_i,weight_i: signed operands
//   result_o      : saturated result
//   ovf_o         : current accumulator would clamp (meaningful with out_en_i)
module conv_mac_lane
  import conv_accum_pkg::*;
#(
  parameter int unsigned BITS      = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_BITS  = 40
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_en_i,
  input  logic            mul_en_i,
  input  logic            acc_en_i,
  input  logic            first_i,
  input  logic            out_en_i,
  input  logic [BITS-1:0] map_i,
  input  logic [BITS-1:0] weight_i,
  output logic [BITS-1:0] result_o,
  output logic            ovf_o
);

  logic signed [BITS-1:0]     map_q, wgt_q;
  logic signed [2*BITS-1:0]   prod_q, prod_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic        [BITS-1:0]     result_q;
  logic signed [63:0]         sat_val;
  logic                       sat_ovf;

  always_comb begin
    prod_d = map_q * wgt_q;
    acc_d  = acc_q;
    if (acc_en_i) begin
      acc_d = first_i ? ACC_BITS'(prod_q) : acc_q + ACC_BITS'(prod_q);
    end
    sat_val = sat_shift(64'(acc_q), FRAC_BITS, BITS, sat_ovf);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q    <= '0;
      wgt_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      if (in_en_i) begin
        map_q <= map_i;
        wgt_q <= weight_i;
      end
      if (mul_en_i) prod_q <= prod_d;
      acc_q <= acc_d;
      if (out_en_i) result_q <= BITS'(sat_val);
    end
  end

  assign result_o = result_q;
  assign ovf_o    = sat_ovf;

endmodule

// File: rtl/conv_accum.sv
// conv_accum: convolution accumulator over weight_num taps per window.
//   clk_in, rst_n : clock, async active-low reset
//   in_valid      : beat qualifier for map/weight
//   map           : channel_all_num signed pixel lanes
//   weight        : conv_num signed kernel taps
//   out_valid     : one-cycle pulse, result valid
//   result        : element (c,p) at [(c*channel_all_num+p)*bits +: bits]
//   frame_done    : pulses with the last window's out_valid
//   overflow      : sticky saturation flag, cleared by reset only
module conv_accum
  import conv_accum_pkg::*;
#(
  parameter int unsigned bits            = BITS_DFLT,
  parameter int unsigned bits_shift      = 4,
  parameter int unsigned channel_all_num = 16,
  parameter int unsigned bits_channel    = 256,
  parameter int unsigned conv_num        = 4,
  parameter int unsigned weight_num      = 25,
  parameter int unsigned weight_num_2    = 5,
  parameter int unsigned frac_bits       = 8,
  parameter int unsigned acc_bits        = ACC_BITS,
  parameter int unsigned window_num      = 1488,
  parameter int unsigned window_num_2    = 11
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [bits_channel-1:0]           map,
  input  logic [(conv_num<<bits_shift)-1:0] weight,
  output logic                              out_valid,
  output logic [conv_num*bits_channel-1:0]  result,
  output logic                              frame_done,
  output logic                              overflow
);

  localparam int unsigned N_ELEM = conv_num * channel_all_num;

  logic [weight_num_2-1:0] tap_q, tap_d;
  logic [window_num_2-1:0] win_q, win_d;
  logic                    tap_first, tap_last, win_last;
  // operand stage, product stage, accumulate stage control
  logic                    s0_valid_q, s0_first_q, s0_last_q;
  logic                    s1_valid_q, s1_first_q, s1_last_q;
  logic                    s2_last_q;
  logic                    out_valid_q, frame_done_q, overflow_q;
  logic [N_ELEM-1:0]       lane_ovf;

  always_comb begin
    tap_first = (tap_q == '0);
    tap_last  = (tap_q == weight_num_2'(weight_num - 1));
    tap_d     = tap_q;
    if (in_valid) tap_d = tap_last ? '0 : tap_q + 1'b1;
    win_last  = (win_q == window_num_2'(window_num - 1));
    win_d     = win_q;
    if (s2_last_q) win_d = win_last ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tap_q        <= '0;
      win_q        <= '0;
      s0_valid_q   <= 1'b0;
      s0_first_q   <= 1'b0;
      s0_last_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_first_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s2_last_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      tap_q        <= tap_d;
      win_q        <= win_d;
      s0_valid_q   <= in_valid;
      s0_first_q   <= in_valid & tap_first;
      s0_last_q    <= in_valid & tap_last;
      s1_valid_q   <= s0_valid_q;
      s1_first_q   <= s0_first_q;
      s1_last_q    <= s0_last_q;
      s2_last_q    <= s1_valid_q & s1_last_q;
      out_valid_q  <= s2_last_q;
      frame_done_q <= s2_last_q & win_last;
      overflow_q   <= overflow_q | (s2_last_q & (|lane_ovf));
    end
  end

  for (genvar c = 0; c < conv_num; c++) begin : g_kern
    for (genvar p = 0; p < channel_all_num; p++) begin : g_lane
      localparam int unsigned E = elem_idx(c, p, channel_all_num);
      conv_mac_lane #(
        .BITS      (bits),
        .FRAC_BITS (frac_bits),
        .ACC_BITS  (acc_bits)
      ) u_lane (
        .clk_i    (clk_in),
        .rst_ni   (rst_n),
        .in_en_i  (in_valid),
        .mul_en_i (s0_valid_q),
        .acc_en_i (s1_valid_q),
        .first_i  (s1_first_q),
        .out_en_i (s2_last_q),
        .map_i    (map[slice_lsb(p, bits) +: bits]),
        .weight_i (weight[slice_lsb(c, bits) +: bits]),
        .result_o (result[slice_lsb(E, bits) +: bits]),
        .ovf_o    (lane_ovf[E])
      );
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_accum.sv
module tb_conv_accum;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [255:0]  map;
  logic [63:0]   weight;
  logic          out_valid;
  logic [1023:0] result;
  logic          frame_done;
  logic          overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ov_q[$];
  logic fd_q[$];
  int win_exp = 0;

  conv_accum #(.window_num(2)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .map        (map),
    .weight     (weight),
    .out_valid  (out_valid),
    .result     (result),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (rst_n && out_valid) begin
      ov_q.push_back(cyc);
      fd_q.push_back(frame_done);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_bad(input logic [15:0] exp);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] e;
      e = result[i*16 +: 16];
      if (e !== exp) n++;
    end
    return n;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    rst_n = 1'b1;
    win_exp = 0;
  endtask

  task automatic send(input logic [15:0] m, input logic [15:0] w, input int n,
                      input int g1, input int g2, input int glen,
                      output int first_c, output int last_c);
    first_c = 0;
    last_c  = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      map      = {16{m}};
      weight   = {4{w}};
      @(posedge clk_in); #1;
      if (i == 0) first_c = cyc;
      last_c = cyc;
      if (i == g1 || i == g2) begin
        in_valid = 1'b0;
        repeat (glen) begin @(posedge clk_in); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(input string tag, input int n);
    for (int k = 0; k < 120 && ov_q.size() < n; k++) begin
      @(negedge clk_in); #1;
    end
    check({tag, "_ovcnt"}, ov_q.size(), n);
  endtask

  // one window of constant data; checks latency, span, values, frame_done, overflow
  task automatic window(input string tag, input logic [15:0] m, input logic [15:0] w,
                        input int g1, input int g2, input int glen, input int span,
                        input logic [15:0] exp, input logic exp_ovf);
    int f, l;
    ov_q.delete();
    fd_q.delete();
    send(m, w, 25, g1, g2, glen, f, l);
    wait_ov(tag, 1);
    if (ov_q.size() > 0) begin
      check({tag, "_lat"}, ov_q[0] - l, 3);
      check({tag, "_span"}, ov_q[0] - f, span);
      check({tag, "_fd"}, 32'(fd_q[0]), 32'(win_exp % 2 == 1));
    end
    win_exp++;
    check({tag, "_e0"}, 32'(result[15:0]), 32'(exp));
    check({tag, "_nbad"}, count_bad(exp), 0);
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    repeat (6) @(negedge clk_in);
    check({tag, "_spur"}, ov_q.size(), 1);
  endtask

  initial begin
    int f, l;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    map      = '0;
    weight   = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    @(negedge clk_in);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_fd", 32'(frame_done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_res", 32'(|result), 0);
    @(posedge clk_in); #1;

    window("pos", 16'h0100, 16'h0100, -1, -1, 0, 27, 16'h1900, 1'b0);
    window("neg", 16'hFF00, 16'h0100, -1, -1, 0, 27, 16'hE700, 1'b0);
    window("sat", 16'h7FFF, 16'h7FFF, -1, -1, 0, 27, 16'h7FFF, 1'b1);
    window("post", 16'h0100, 16'h0100, -1, -1, 0, 27, 16'h1900, 1'b1);
    window("gap", 16'h0100, 16'h0100, 5, 20, 3, 33, 16'h1900, 1'b1);

    // back-to-back windows after reset: frame_done on the 2nd, wrap for the 3rd
    do_reset();
    check("rst2_ovf", 32'(overflow), 0);
    check("rst2_res", 32'(|result), 0);
    ov_q.delete();
    fd_q.delete();
    send(16'h0100, 16'h0100, 75, -1, -1, 0, f, l);
    wait_ov("b2b", 3);
    if (ov_q.size() == 3) begin
      check("b2b_lat0", ov_q[0] - f, 27);
      check("b2b_gap1", ov_q[1] - ov_q[0], 25);
      check("b2b_gap2", ov_q[2] - ov_q[1], 25);
      check("b2b_fd0", 32'(fd_q[0]), 0);
      check("b2b_fd1", 32'(fd_q[1]), 1);
      check("b2b_fd2", 32'(fd_q[2]), 0);
    end
    check("b2b_nbad", count_bad(16'h1900), 0);

    // reset mid-window discards the partial sum
    ov_q.delete();
    fd_q.delete();
    send(16'h7FFF, 16'h7FFF, 13, -1, -1, 0, f, l);
    do_reset();
    send(16'h0100, 16'h0100, 25, -1, -1, 0, f, l);
    wait_ov("mrst", 1);
    repeat (6) @(negedge clk_in);
    check("mrst_cnt", ov_q.size(), 1);
    if (ov_q.size() > 0) check("mrst_lat", ov_q[0] - l, 3);
    check("mrst_e0", 32'(result[15:0]), 32'h1900);
    check("mrst_nbad", count_bad(16'h1900), 0);
    check("mrst_ovf", 32'(overflow), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
